// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU definitions for the instruction-fetch path: address/word types,
// the fetch sequencer state encoding and the fixed reset/exception vectors.
package fetch_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam addr_t CPU_RESET_PC = 32'hbfc0_0000;
    localparam addr_t CPU_EXC_PC   = 32'hbfc0_0380;

    // REQ: address phase, WAIT: data phase, HOLD: decode stalled on a word,
    // DROP: waiting out a response that belongs to a redirected-away path.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps at most one ibus
// request outstanding, applies branch/exception redirects, discards stale
// responses and offers instruction/PC pairs to decode under stall_d.
//
// Ports:
//   clk, resetn                 clock, synchronous active-low reset
//   exc_valid                   exception redirect to EXC_PC (highest priority)
//   redirect_valid/redirect_pc  branch/jump redirect from execute
//   stall_d                     decode cannot accept the offered slot
//   ireq_valid/ireq_addr        ibus address request
//   ireq_addr_ok                ibus accepted the address this cycle
//   iresp_data_ok/iresp_data    ibus returns an instruction this cycle
//   instr_valid/instr/instr_pc  slot offered to decode
//   instr_adel                  offered slot is a misaligned-PC address error
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter addr_t RESET_PC = CPU_RESET_PC,
    parameter addr_t EXC_PC   = CPU_EXC_PC
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exc_valid,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall_d,
    output logic              ireq_valid,
    output logic [ADDR_W-1:0] ireq_addr,
    input  logic              ireq_addr_ok,
    input  logic              iresp_data_ok,
    input  logic [WORD_W-1:0] iresp_data,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_adel
);

    fetch_state_t state_q;
    addr_t        pc_q;
    word_t        hold_q;

    logic  redir;
    addr_t tgt;
    addr_t pc_inc;
    logic  misaligned;

    assign redir      = exc_valid | redirect_valid;
    assign tgt        = exc_valid ? EXC_PC : redirect_pc;
    assign pc_inc     = pc_q + ADDR_W'(4);
    assign misaligned = (pc_q[1:0] != 2'b00);

    // Sequencer state, fetch PC and the single-entry hold buffer.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            hold_q  <= '0;
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (misaligned) begin
                        // No bus request; the adel slot is retired like a fetched word.
                        if (redir)         pc_q <= tgt;
                        else if (!stall_d) pc_q <= pc_inc;
                    end else if (ireq_addr_ok) begin
                        if (redir) begin
                            pc_q    <= tgt;
                            state_q <= ST_DROP;
                        end else begin
                            state_q <= ST_WAIT;
                        end
                    end else if (redir) begin
                        pc_q <= tgt;
                    end
                end
                ST_WAIT: begin
                    if (redir) begin
                        pc_q    <= tgt;
                        state_q <= iresp_data_ok ? ST_REQ : ST_DROP;
                    end else if (iresp_data_ok) begin
                        if (!stall_d) begin
                            pc_q    <= pc_inc;
                            state_q <= ST_REQ;
                        end else begin
                            hold_q  <= iresp_data;
                            state_q <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redir) begin
                        hold_q  <= '0;
                        pc_q    <= tgt;
                        state_q <= ST_REQ;
                    end else if (!stall_d) begin
                        pc_q    <= pc_inc;
                        state_q <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    // A redirect and the stale response may coincide; honour both.
                    if (redir)         pc_q    <= tgt;
                    if (iresp_data_ok) state_q <= ST_REQ;
                end
            endcase
        end
    end

    // Bus request and decode slot; any redirect masks the decode slot.
    always_comb begin
        ireq_valid  = 1'b0;
        ireq_addr   = '0;
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        instr_adel  = 1'b0;
        if (resetn) begin
            unique case (state_q)
                ST_REQ: begin
                    if (misaligned) begin
                        if (!redir) begin
                            instr_valid = 1'b1;
                            instr_adel  = 1'b1;
                            instr_pc    = pc_q;
                        end
                    end else begin
                        ireq_valid = 1'b1;
                        ireq_addr  = pc_q;
                    end
                end
                ST_WAIT: begin
                    if (iresp_data_ok && !redir) begin
                        instr_valid = 1'b1;
                        instr       = iresp_data;
                        instr_pc    = pc_q;
                    end
                end
                ST_HOLD: begin
                    if (!redir) begin
                        instr_valid = 1'b1;
                        instr       = hold_q;
                        instr_pc    = pc_q;
                    end
                end
                ST_DROP: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: each cycle drives the inputs just after the
// rising edge and compares outputs against hand-computed values on the
// falling edge.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_adel;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .exc_valid     (exc_valid),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall_d       (stall_d),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .ireq_addr_ok  (ireq_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_adel    (instr_adel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h @%0t", tag, got, exp, $time);
        end
    endtask

    // Commit the previous cycle on the rising edge, apply new inputs, settle to the falling edge.
    task automatic cyc(input logic rn, input logic exc, input logic rv, input logic [31:0] rpc,
                       input logic stall, input logic aok, input logic dok, input logic [31:0] data);
        @(posedge clk);
        #1;
        resetn         = rn;
        exc_valid      = exc;
        redirect_valid = rv;
        redirect_pc    = rpc;
        stall_d        = stall;
        ireq_addr_ok   = aok;
        iresp_data_ok  = dok;
        iresp_data     = data;
        @(negedge clk);
    endtask

    initial begin
        resetn = 1'b0; exc_valid = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        stall_d = 1'b0; ireq_addr_ok = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;

        // Reset: everything quiet.
        cyc(0, 0, 0, 32'h0, 0, 1, 1, 32'hffff_ffff);
        cyc(0, 0, 0, 32'h0, 0, 1, 1, 32'hffff_ffff);
        chk("rst_ireq_valid", 32'(ireq_valid), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_adel", 32'(instr_adel), 32'd0);

        // Zero-wait bus: one instruction every two cycles.
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("b2b_req0_valid", 32'(ireq_valid), 32'd1);
        chk("b2b_req0_addr", ireq_addr, 32'hbfc0_0000);
        chk("b2b_req0_ivalid", 32'(instr_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 1, 32'hdead_0000);
        chk("b2b_rsp0_ireq", 32'(ireq_valid), 32'd0);
        chk("b2b_rsp0_ivalid", 32'(instr_valid), 32'd1);
        chk("b2b_rsp0_instr", instr, 32'hdead_0000);
        chk("b2b_rsp0_pc", instr_pc, 32'hbfc0_0000);
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("b2b_req1_addr", ireq_addr, 32'hbfc0_0004);
        chk("b2b_req1_ivalid", 32'(instr_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 1, 32'hdead_0004);
        chk("b2b_rsp1_ivalid", 32'(instr_valid), 32'd1);
        chk("b2b_rsp1_pc", instr_pc, 32'hbfc0_0004);

        // Decode stall across a returned word: offered four cycles, no new request.
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("stall_req_addr", ireq_addr, 32'hbfc0_0008);
        cyc(1, 0, 0, 32'h0, 1, 0, 1, 32'h1234_5678);
        chk("stall_c0_ivalid", 32'(instr_valid), 32'd1);
        chk("stall_c0_instr", instr, 32'h1234_5678);
        chk("stall_c0_pc", instr_pc, 32'hbfc0_0008);
        for (int i = 1; i <= 3; i++) begin
            cyc(1, 0, 0, 32'h0, (i < 3) ? 1'b1 : 1'b0, 0, 0, 32'h0);
            chk($sformatf("stall_c%0d_ivalid", i), 32'(instr_valid), 32'd1);
            chk($sformatf("stall_c%0d_instr", i), instr, 32'h1234_5678);
            chk($sformatf("stall_c%0d_ireq", i), 32'(ireq_valid), 32'd0);
        end
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("stall_next_valid", 32'(ireq_valid), 32'd1);
        chk("stall_next_addr", ireq_addr, 32'hbfc0_000c);
        chk("stall_next_ivalid", 32'(instr_valid), 32'd0);

        // Redirect while waiting for data: stale response dropped.
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        cyc(1, 0, 1, 32'hbfc0_0100, 0, 0, 0, 32'h0);
        chk("drop_redir_ivalid", 32'(instr_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("drop_wait_ireq", 32'(ireq_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 1, 32'hbad0_bad0);
        chk("drop_stale_ivalid", 32'(instr_valid), 32'd0);
        chk("drop_stale_ireq", 32'(ireq_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("drop_next_valid", 32'(ireq_valid), 32'd1);
        chk("drop_next_addr", ireq_addr, 32'hbfc0_0100);

        // Exception and branch together in REQ without addr_ok: exception wins.
        cyc(1, 1, 1, 32'hbfc0_0200, 0, 0, 0, 32'h0);
        chk("exc_same_cycle_addr", ireq_addr, 32'hbfc0_0100);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("exc_addr", ireq_addr, 32'hbfc0_0380);
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("exc_addr_hold", ireq_addr, 32'hbfc0_0380);
        cyc(1, 0, 0, 32'h0, 0, 0, 1, 32'haaaa_aaaa);
        chk("exc_rsp_pc", instr_pc, 32'hbfc0_0380);

        // Redirect in the same cycle as data_ok.
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("rdok_req_addr", ireq_addr, 32'hbfc0_0384);
        cyc(1, 0, 1, 32'hbfc0_0400, 0, 0, 1, 32'hbbbb_bbbb);
        chk("rdok_ivalid", 32'(instr_valid), 32'd0);
        cyc(1, 0, 1, 32'hbfc0_0102, 0, 0, 0, 32'h0);
        chk("rdok_next_valid", 32'(ireq_valid), 32'd1);
        chk("rdok_next_addr", ireq_addr, 32'hbfc0_0400);

        // Misaligned target: adel slot, no bus request, then next misaligned slot.
        cyc(1, 0, 0, 32'h0, 1, 1, 0, 32'h0);
        chk("adel0_ireq", 32'(ireq_valid), 32'd0);
        chk("adel0_ivalid", 32'(instr_valid), 32'd1);
        chk("adel0_adel", 32'(instr_adel), 32'd1);
        chk("adel0_pc", instr_pc, 32'hbfc0_0102);
        chk("adel0_instr", instr, 32'h0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("adel0_held_pc", instr_pc, 32'hbfc0_0102);
        cyc(1, 0, 0, 32'h0, 1, 0, 0, 32'h0);
        chk("adel1_ireq", 32'(ireq_valid), 32'd0);
        chk("adel1_adel", 32'(instr_adel), 32'd1);
        chk("adel1_pc", instr_pc, 32'hbfc0_0106);
        cyc(1, 0, 1, 32'hffff_fffc, 1, 0, 0, 32'h0);
        chk("adel_redir_masked", 32'(instr_valid), 32'd0);

        // PC wrap at the top of the address space.
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("wrap_req_addr", ireq_addr, 32'hffff_fffc);
        cyc(1, 0, 0, 32'h0, 0, 0, 1, 32'h1111_1111);
        chk("wrap_rsp_pc", instr_pc, 32'hffff_fffc);
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        chk("wrap_next_addr", ireq_addr, 32'h0000_0000);
        chk("wrap_next_valid", 32'(ireq_valid), 32'd1);

        // Exception while holding a stalled word.
        cyc(1, 0, 0, 32'h0, 1, 0, 1, 32'h2222_2222);
        chk("hold_first_pc", instr_pc, 32'h0000_0000);
        cyc(1, 1, 0, 32'h0, 1, 0, 0, 32'h0);
        chk("hold_exc_masked", 32'(instr_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("hold_exc_addr", ireq_addr, 32'hbfc0_0380);

        // Reset mid-request returns to RESET_PC.
        cyc(1, 0, 0, 32'h0, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("rst_mid_ireq", 32'(ireq_valid), 32'd0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("rst_mid_addr", ireq_addr, 32'hbfc0_0000);
        chk("rst_mid_valid", 32'(ireq_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
